// File: rtl/lsu_if.sv
// Execute-to-LSU request, data-memory request/response and writeback signals of the lsu block.
// The slave modport is the LSU's own view; the master modport is its environment's view.
interface lsu_if;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_mem_op;
  logic [4:0]  lsu_rd_addr;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        lsu_err;

  modport slave (
    input  lsu_valid, lsu_addr, lsu_wdata, lsu_mem_op, lsu_rd_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output lsu_ready,
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    output wb_valid, wb_rd_addr, wb_data, lsu_err
  );

  modport master (
    output lsu_valid, lsu_addr, lsu_wdata, lsu_mem_op, lsu_rd_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  lsu_ready,
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
    input  wb_valid, wb_rd_addr, wb_data, lsu_err
  );
endinterface

// File: rtl/lsu.sv
// Blocking load/store unit: one execute request at a time onto a word-addressed memory port.
// Defining LSU_TIMEOUT_EN adds a WAIT-state timeout abort after TIMEOUT_CYCLES idle cycles.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

  localparam logic [1:0] OpNone = 2'd0;
  localparam logic [1:0] OpLw   = 2'd1;
  localparam logic [1:0] OpSw   = 2'd2;
  localparam logic [1:0] OpLbu  = 2'd3;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu: TIMEOUT_CYCLES must be nonzero");
  end

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;
  logic        mem_req_we_q, mem_req_we_d;
  logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [3:0]  mem_req_wstrb_q, mem_req_wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        lsu_err_q, lsu_err_d;
  logic        go_mem;
  logic [7:0]  lbu_byte;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  // LBU goes to memory at any address; word ops only when word aligned.
  assign go_mem = (bus.lsu_mem_op == OpLbu) ||
                  (((bus.lsu_mem_op == OpLw) || (bus.lsu_mem_op == OpSw)) &&
                   (bus.lsu_addr[1:0] == 2'b00));

  assign lbu_byte = bus.mem_resp_rdata[{off_q, 3'b000} +: 8];

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    rd_d            = rd_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wstrb_d = mem_req_wstrb_q;
    wb_valid_d      = 1'b0;
    wb_rd_addr_d    = wb_rd_addr_q;
    wb_data_d       = wb_data_q;
    lsu_err_d       = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d           = cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.lsu_valid) begin
          op_d  = bus.lsu_mem_op;
          rd_d  = bus.lsu_rd_addr;
          off_d = bus.lsu_addr[1:0];
          if (go_mem) begin
            state_d         = StReq;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {bus.lsu_addr[31:2], 2'b00};
            mem_req_we_d    = (bus.lsu_mem_op == OpSw);
            mem_req_wdata_d = bus.lsu_wdata;
            mem_req_wstrb_d = (bus.lsu_mem_op == OpSw) ? 4'hF : 4'h0;
          end else if (bus.lsu_mem_op != OpNone) begin
            lsu_err_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (bus.mem_req_ready) begin
          state_d         = StWait;
          mem_req_valid_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      StWait: begin
        if (bus.mem_resp_valid) begin
          if ((op_q == OpSw) || (rd_q == 5'd0)) begin
            state_d = StIdle;
          end else begin
            state_d      = StWb;
            wb_valid_d   = 1'b1;
            wb_rd_addr_d = rd_q;
            wb_data_d    = (op_q == OpLbu) ? {24'h0, lbu_byte} : bus.mem_resp_rdata;
          end
        end
`ifdef LSU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
            state_d   = StIdle;
            lsu_err_d = 1'b1;
          end
        end
`endif
      end
      StWb: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      op_q            <= OpNone;
      rd_q            <= '0;
      off_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_we_q    <= 1'b0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= '0;
      wb_valid_q      <= 1'b0;
      wb_rd_addr_q    <= '0;
      wb_data_q       <= '0;
      lsu_err_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      rd_q            <= rd_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wstrb_q <= mem_req_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_addr_q    <= wb_rd_addr_d;
      wb_data_q       <= wb_data_d;
      lsu_err_q       <= lsu_err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q           <= cnt_d;
`endif
    end
  end

  assign bus.lsu_ready     = (state_q == StIdle);
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wstrb = mem_req_wstrb_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd_addr    = wb_rd_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.lsu_err       = lsu_err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: drives one transaction at a time and checks every output against a
// transaction-level model; inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu;

  localparam logic [1:0] OpNone = 2'd0;
  localparam logic [1:0] OpLw   = 2'd1;
  localparam logic [1:0] OpSw   = 2'd2;
  localparam logic [1:0] OpLbu  = 2'd3;

  logic clk;
  logic rst;
  lsu_if bus ();

  lsu #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        is_mem;
    logic        is_err;
    logic [31:0] req_addr;
    logic        we;
    logic [3:0]  wstrb;
    logic        has_wb;
  } exp_t;

  // What a transaction must do, derived from op, address and destination alone.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [4:0] rd);
    exp_t e;
    e = '0;
    e.req_addr = addr & 32'hFFFF_FFFC;
    if (op == OpLbu) e.is_mem = 1'b1;
    else if (op == OpLw || op == OpSw) begin
      if (addr % 4 != 0) e.is_err = 1'b1;
      else e.is_mem = 1'b1;
    end
    e.we     = (op == OpSw);
    e.wstrb  = (op == OpSw) ? 4'hF : 4'h0;
    e.has_wb = e.is_mem && (op != OpSw) && (rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] model_wb(input logic [1:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    if (op == OpLw) return rdata;
    return (rdata >> (8 * (addr % 4))) & 32'h0000_00FF;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_ready"}, 32'(bus.lsu_ready), 32'd1);
    check_eq({pfx, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    check_eq({pfx, "_req_we"}, 32'(bus.mem_req_we), 32'd0);
    check_eq({pfx, "_req_wstrb"}, 32'(bus.mem_req_wstrb), 32'd0);
    check_eq({pfx, "_req_addr"}, bus.mem_req_addr, 32'd0);
    check_eq({pfx, "_req_wdata"}, bus.mem_req_wdata, 32'd0);
    check_eq({pfx, "_wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check_eq({pfx, "_wb_rd"}, 32'(bus.wb_rd_addr), 32'd0);
    check_eq({pfx, "_wb_data"}, bus.wb_data, 32'd0);
    check_eq({pfx, "_err"}, 32'(bus.lsu_err), 32'd0);
  endtask

  // Starts and ends on a falling edge where the LSU is expected idle.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input int ready_dly, input int resp_dly,
                         input logic [31:0] rdata);
    exp_t e;
    e = model(op, addr, rd);
    check_eq("idle_ready", 32'(bus.lsu_ready), 32'd1);
    bus.lsu_valid   = 1'b1;
    bus.lsu_mem_op  = op;
    bus.lsu_addr    = addr;
    bus.lsu_wdata   = wdata;
    bus.lsu_rd_addr = rd;
    @(negedge clk);
    // Execute inputs after accept must be ignored.
    bus.lsu_valid   = 1'b0;
    bus.lsu_mem_op  = 2'($urandom);
    bus.lsu_addr    = $urandom;
    bus.lsu_wdata   = $urandom;
    bus.lsu_rd_addr = 5'($urandom);
    check_eq("err_pulse", 32'(bus.lsu_err), 32'(e.is_err));
    check_eq("req_valid", 32'(bus.mem_req_valid), 32'(e.is_mem));
    check_eq("ready_after_accept", 32'(bus.lsu_ready), 32'(!e.is_mem));
    check_eq("wb_idle", 32'(bus.wb_valid), 32'd0);
    if (!e.is_mem) return;
    for (int i = 0; i <= ready_dly; i++) begin
      check_eq("req_hold_valid", 32'(bus.mem_req_valid), 32'd1);
      check_eq("req_addr", bus.mem_req_addr, e.req_addr);
      check_eq("req_we", 32'(bus.mem_req_we), 32'(e.we));
      check_eq("req_wdata", bus.mem_req_wdata, wdata);
      check_eq("req_wstrb", 32'(bus.mem_req_wstrb), 32'(e.wstrb));
      bus.mem_req_ready  = (i == ready_dly);
      bus.mem_resp_valid = 1'($urandom_range(0, 1));
      bus.mem_resp_rdata = $urandom;
      @(negedge clk);
    end
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i <= resp_dly; i++) begin
      check_eq("wait_ready", 32'(bus.lsu_ready), 32'd0);
      check_eq("wait_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check_eq("wait_wb", 32'(bus.wb_valid), 32'd0);
      if (i < resp_dly) @(negedge clk);
    end
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = rdata;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = $urandom;
    check_eq("wb_valid", 32'(bus.wb_valid), 32'(e.has_wb));
    if (e.has_wb) begin
      check_eq("wb_rd", 32'(bus.wb_rd_addr), 32'(rd));
      check_eq("wb_data", bus.wb_data, model_wb(op, addr, rdata));
      check_eq("wb_ready", 32'(bus.lsu_ready), 32'd0);
      @(negedge clk);
      check_eq("wb_pulse_end", 32'(bus.wb_valid), 32'd0);
    end
    check_eq("done_ready", 32'(bus.lsu_ready), 32'd1);
  endtask

  // Accepts an aligned LW and completes the request handshake; returns on the first WAIT cycle.
  task automatic enter_wait(input logic [31:0] addr, input logic [4:0] rd);
    bus.lsu_valid   = 1'b1;
    bus.lsu_mem_op  = OpLw;
    bus.lsu_addr    = addr;
    bus.lsu_rd_addr = rd;
    @(negedge clk);
    bus.lsu_valid     = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check_eq("enter_wait_ready", 32'(bus.lsu_ready), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        err_seen;

    rst                = 1'b1;
    bus.lsu_valid      = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wdata      = '0;
    bus.lsu_mem_op     = OpNone;
    bus.lsu_rd_addr    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_txn(OpLw, 32'h8000_0004, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
    run_txn(OpSw, 32'h0000_0100, 32'h1234_5678, 5'd3, 3, 0, 32'h0);
    run_txn(OpLbu, 32'h0000_0203, 32'h0, 5'd9, 0, 1, 32'hAABB_CCDD);
    run_txn(OpLbu, 32'h0000_0200, 32'h0, 5'd9, 1, 0, 32'hAABB_CCDD);
    run_txn(OpLw, 32'h0000_0102, 32'h0, 5'd4, 0, 0, 32'h0);
    run_txn(OpSw, 32'h0000_0101, 32'hFFFF_FFFF, 5'd4, 0, 0, 32'h0);
    run_txn(OpLw, 32'h0000_0040, 32'h0, 5'd0, 0, 2, 32'h5555_AAAA);
    run_txn(OpNone, 32'h0000_0044, 32'h0, 5'd6, 0, 0, 32'h0);
    run_txn(OpLbu, 32'h0000_0301, 32'h0, 5'd31, 2, 2, 32'h1122_3344);

    for (int n = 0; n < 300; n++) begin
      op   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_txn(op, addr, $urandom, rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    enter_wait(32'h0000_0500, 5'd8);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check_eq("to_wait_ready", 32'(bus.lsu_ready), 32'd0);
      check_eq("to_wait_err", 32'(bus.lsu_err), 32'd0);
      @(negedge clk);
    end
    check_eq("to_err", 32'(bus.lsu_err), 32'd1);
    check_eq("to_ready", 32'(bus.lsu_ready), 32'd1);
    check_eq("to_wb", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    check_eq("to_err_end", 32'(bus.lsu_err), 32'd0);
    check_eq("to_wb_end", 32'(bus.wb_valid), 32'd0);
    enter_wait(32'h0000_0600, 5'd7);
`else
    err_seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      err_seen = err_seen | bus.lsu_err | bus.wb_valid;
    end
    check_eq("stuck_wait_ready", 32'(bus.lsu_ready), 32'd0);
    check_eq("stuck_wait_quiet", 32'(err_seen), 32'd0);
`endif

    // Reset in WAIT, then a stale response must not produce a writeback.
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check_reset_outputs("stale_resp");
    @(negedge clk);
    check_eq("stale_wb_later", 32'(bus.wb_valid), 32'd0);

    run_txn(OpLw, 32'h0000_0010, 32'h0, 5'd12, 0, 0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
